// File: rtl/perceptron_layer_seq.sv
// Sequences one shared perceptron over NUM_NEURONS neurons; 3 cycles per neuron, results held stable while res_ready is low.
// Build option SEQ_RELU_EN: clamp negative captured results to zero.
module perceptron_layer_seq #(
    parameter int NUM_NEURONS = 4,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [7:0]        cfg_data,
    input  logic              start,
    input  logic [7:0]        in_vec,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_idx,
    output logic [7:0]        res_data,
    output logic [7:0]        p_in,
    output logic [63:0]       p_weight,
    output logic [7:0]        p_bias,
    input  logic [7:0]        p_out
);

    localparam int         MAX_N    = 16;
    localparam logic [3:0] LAST_IDX = 4'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, OUT} state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] idx;
    logic [7:0] wt   [MAX_N][8];
    logic [7:0] bias [MAX_N];
    logic [7:0] capt_val;
    logic       accept;
    logic       capture;
    logic       advance;
    logic       finish;

    assign busy      = (state != IDLE);
    assign res_valid = (state == OUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        advance  = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ISSUE;
                    accept   = 1'b1;
                end
            end
            ISSUE: state_nx = CAPT;
            CAPT: begin
                state_nx = OUT;
                capture  = 1'b1;
            end
            OUT: begin
                if (res_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nx = IDLE;
                        finish   = 1'b1;
                    end else begin
                        state_nx = ISSUE;
                        advance  = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef SEQ_RELU_EN
    assign capt_val = p_out[7] ? 8'h00 : p_out;
`else
    assign capt_val = p_out;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= 4'd0;
            p_in     <= 8'h00;
            res_idx  <= 4'd0;
            res_data <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                p_in <= in_vec;
                idx  <= 4'd0;
            end else if (advance) begin
                idx <= idx + 4'd1;
            end
            if (capture) begin
                res_data <= capt_val;
                res_idx  <= idx;
            end
        end
    end

    // Slots beyond NUM_NEURONS stay at their reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < MAX_N; n++) begin
                bias[n] <= 8'h00;
                for (int k = 0; k < 8; k++) begin
                    wt[n][k] <= 8'h00;
                end
            end
        end else if (cfg_we && !busy) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                for (int k = 0; k < 8; k++) begin
                    if (cfg_addr == ADDR_W'(n * 9 + k)) begin
                        wt[n][k] <= cfg_data;
                    end
                end
                if (cfg_addr == ADDR_W'(n * 9 + 8)) begin
                    bias[n] <= cfg_data;
                end
            end
        end
    end

    always_comb begin
        p_weight = 64'h0;
        for (int k = 0; k < 8; k++) begin
            p_weight[8*k +: 8] = wt[idx][k];
        end
    end

    assign p_bias = bias[idx];

endmodule

// File: tb/tb_perceptron_layer_seq.sv
// Bench for perceptron_layer_seq: behavioural perceptron, reference register model and result scoreboard.
`timescale 1ns/1ps
module tb_perceptron_layer_seq;

    localparam int N  = 4;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [7:0]    cfg_data;
    logic          start;
    logic [7:0]    in_vec;
    logic          busy;
    logic          done;
    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_idx;
    logic [7:0]    res_data;
    logic [7:0]    p_in;
    logic [63:0]   p_weight;
    logic [7:0]    p_bias;
    logic [7:0]    p_out = 8'h00;

    always #5 clk = ~clk;

    perceptron_layer_seq #(.NUM_NEURONS(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .in_vec(in_vec), .busy(busy), .done(done), .res_valid(res_valid),
        .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data), .p_in(p_in),
        .p_weight(p_weight), .p_bias(p_bias), .p_out(p_out)
    );

    function automatic logic [7:0] dot8(input logic [7:0] v, input logic [63:0] w, input logic [7:0] b);
        logic [7:0] acc;
        acc = b;
        for (int k = 0; k < 8; k++) begin
            if (v[k]) acc = acc + w[8*k +: 8];
        end
        return acc;
    endfunction

    // Shared perceptron: registered, one-cycle latency.
    always @(posedge clk) p_out <= dot8(p_in, p_weight, p_bias);

    logic [7:0] m_w [N][8];
    logic [7:0] m_b [N];

    function automatic logic [7:0] model(input int n, input logic [7:0] v);
        logic [63:0] w;
        logic [7:0]  r;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = m_w[n][k];
        r = dot8(v, w, m_b[n]);
`ifdef SEQ_RELU_EN
        if (r[7]) r = 8'h00;
`endif
        return r;
    endfunction

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] data;
    } res_t;

    res_t sb[$];
    res_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst && res_valid && res_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed idx=%0d data=%0h expected=none", res_idx, res_data);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("res_idx", 32'(res_idx), 32'(mon_e.idx));
                check("res_data", 32'(res_data), 32'(mon_e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
        if (a % 9 == 8) m_b[a / 9] = d;
        else m_w[a / 9][a % 9] = d;
    endtask

    task automatic push_run(input logic [7:0] v);
        for (int n = 0; n < N; n++) sb.push_back('{idx: 4'(n), data: model(n, v)});
    endtask

    task automatic start_run(input logic [7:0] v);
        in_vec = v;
        start  = 1'b1;
        push_run(v);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_valid_idx(input logic [3:0] i);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (res_valid && res_idx == i) seen = 1'b1;
        end
        check("valid_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int dc;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = 8'h00;
        start = 1'b0; in_vec = 8'h00; res_ready = 1'b1;
        for (int n = 0; n < N; n++) begin
            m_b[n] = 8'h00;
            for (int k = 0; k < 8; k++) m_w[n][k] = 8'h00;
        end
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_idx", 32'(res_idx), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        check("rst_p_in", 32'(p_in), 32'd0);
        tick();
        rst = 1'b0;

        // Basic: all-ones weights on neuron0, result 8 two edges after acceptance.
        for (int k = 0; k < 8; k++) cfg_write(k, 8'h01);
        start_run(8'hFF);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_valid_e0", 32'(res_valid), 32'd0);
        check("basic_p_in", 32'(p_in), 32'hFF);
        tick();
        check("basic_valid_e1", 32'(res_valid), 32'd0);
        tick();
        check("basic_valid_e2", 32'(res_valid), 32'd1);
        check("basic_idx0", 32'(res_idx), 32'd0);
        wait_done(cyc);
        check("basic_cycles", 32'(cyc + 2), 32'(3 * N));
        check("basic_busy_done", 32'(busy), 32'd0);
        tick();
        check("basic_done_pulse", 32'(done), 32'd0);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);

        // Multi-neuron: only neuron1 contributes.
        for (int k = 0; k < 8; k++) cfg_write(k, 8'h00);
        cfg_write(9, 8'h03);
        cfg_write(17, 8'h05);
        start_run(8'h01);
        wait_done(cyc);
        check("multi_cycles", 32'(cyc), 32'(3 * N));
        tick();
        check("multi_done_cnt", 32'(done_cnt), 32'd2);
        check("multi_sb_empty", 32'(sb.size()), 32'd0);

        // Wrap: 9 * 0xFF modulo 256.
        for (int k = 0; k < 8; k++) cfg_write(k, 8'hFF);
        cfg_write(8, 8'hFF);
        start_run(8'hFF);
        wait_done(cyc);
        tick();
        check("wrap_done_cnt", 32'(done_cnt), 32'd3);

        // Backpressure on idx1 with an ignored start and config write during the stall.
        start_run(8'h0F);
        wait_valid_idx(4'd1);
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start    = (i == 1);
            in_vec   = (i == 1) ? 8'hAA : 8'h0F;
            cfg_we   = (i == 2);
            cfg_addr = AW'(17);
            cfg_data = 8'h77;
            tick();
            check("stall_valid", 32'(res_valid), 32'd1);
            check("stall_idx", 32'(res_idx), 32'd1);
            check("stall_data", 32'(res_data), 32'(model(1, 8'h0F)));
            check("stall_p_in", 32'(p_in), 32'h0F);
        end
        start = 1'b0; cfg_we = 1'b0; res_ready = 1'b1;
        wait_done(cyc);
        tick();
        check("stall_start_ignored", 32'(busy), 32'd0);
        check("stall_sb_empty", 32'(sb.size()), 32'd0);
        start_run(8'h0F);
        wait_done(cyc);
        tick();
        check("stall_done_cnt", 32'(done_cnt), 32'd5);

        // Reset during idx2 capture.
        start_run(8'h01);
        wait_valid_idx(4'd1);
        tick();
        tick();
        dc  = done_cnt;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_data", 32'(res_data), 32'd0);
        check("mid_rst_p_in", 32'(p_in), 32'd0);
        sb.delete();
        for (int n = 0; n < N; n++) begin
            m_b[n] = 8'h00;
            for (int k = 0; k < 8; k++) m_w[n][k] = 8'h00;
        end
        tick();
        check("mid_rst_busy_next", 32'(busy), 32'd0);
        check("mid_rst_valid_next", 32'(res_valid), 32'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("mid_rst_no_done", 32'(done_cnt), 32'(dc));
        cfg_write(19, 8'h20);
        cfg_write(35, 8'h11);
        start_run(8'h02);
        wait_done(cyc);
        tick();
        check("mid_rst_done_cnt", 32'(done_cnt), 32'(dc + 1));

        // Back-to-back: start held through the done cycle.
        in_vec = 8'h02;
        start  = 1'b1;
        push_run(8'h02);
        push_run(8'h02);
        tick();
        wait_done(cyc);
        check("b2b_cycles1", 32'(cyc), 32'(3 * N));
        tick();
        check("b2b_restart", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(cyc);
        check("b2b_cycles2", 32'(cyc), 32'(3 * N));
        tick();
        check("b2b_done_cnt", 32'(done_cnt), 32'(dc + 3));
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perceptron_layer_seq.md
# perceptron_layer_seq

Sequencer that time-multiplexes one `perceptron` instance across `NUM_NEURONS` logical neurons to evaluate one fully connected layer. It holds per-neuron weight and bias registers, loaded over a config write port. On `start` it latches an 8-bit input vector and presents each neuron's weights to the perceptron in turn. Each neuron's result is returned over a valid/ready stream, and `done` pulses when the layer finishes. It sits between the layer-level control and the shared `perceptron` datapath.

## Interface
- `NUM_NEURONS`, default 4: number of logical neurons, range 1..16.
- `ADDR_W`, default 6: config address width. Must satisfy 2^ADDR_W ≥ 9*NUM_NEURONS.
- `clk`  in  1  clock, all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cfg_we`  in  1  config write strobe.
- `cfg_addr`  in  ADDR_W  register address: neuron n, slot k at n*9+k. k=0..7 is weight0..7; k=8 is bias.
- `cfg_data`  in  8  write data.
- `start`  in  1  begin a layer evaluation; sampled only in IDLE.
- `in_vec`  in  8  input bit vector, latched when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last result handshake.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_idx`  out  4  neuron index of the current result.
- `res_data`  out  8  result value.
- `p_in`  out  8  to perceptron `in`; equals the latched vector.
- `p_weight`  out  64  to perceptron weight0..7; weightk is bits [8k+7:8k].
- `p_bias`  out  8  to perceptron `bias`.
- `p_out`  in  8  from perceptron `out`; registered, 1-cycle latency.

## Operation
- Register file: 9*NUM_NEURONS bytes.
  - All bytes reset to 0.
  - A write is accepted when `cfg_we`=1, `busy`=0, and `cfg_addr` < 9*NUM_NEURONS.
  - Writes are silently dropped while `busy`=1 or when the address is out of range.
- FSM states: IDLE, ISSUE, CAPT, OUT.
  - IDLE: when `start`=1, latch `in_vec`, set idx=0, go to ISSUE.
  - ISSUE: drive `p_weight`/`p_bias` from neuron idx; go to CAPT.
  - CAPT: `p_out` now holds neuron idx's sum; register it (after the optional ReLU) into `res_data`, set `res_idx`=idx, go to OUT.
  - OUT: `res_valid`=1. When `res_ready`=1: if idx=NUM_NEURONS-1, go to IDLE and pulse `done`; else increment idx and go to ISSUE. When `res_ready`=0, hold.
- `p_weight`/`p_bias` always reflect neuron idx; they are don't-care outside ISSUE. `p_in` holds the latched vector.
- Arithmetic is done by the perceptron: 8-bit result modulo 256. The sequencer does no widening.
- `start` while `busy`=1 is ignored. `start` in the `done` cycle is accepted (state is already IDLE).
- `cfg_we` and `start` in the same IDLE cycle: the write lands, but the neuron reads during that run see the new value only from the next ISSUE onward. The write commits at the same edge `start` is accepted, so it is visible to the run.

## Timing
- Reset values: `busy`=0, `done`=0, `res_valid`=0, `res_idx`=0, `res_data`=0, `p_in`=0, state=IDLE, idx=0.
- With `start` accepted at edge E0:
  - ISSUE runs in cycle E0..E1.
  - CAPT runs in cycle E1..E2.
  - `res_valid` rises after E2.
- Each neuron takes 3 cycles at `res_ready`=1. A full layer takes 3*NUM_NEURONS cycles from start to the last handshake.
- `done` is high for exactly one cycle, following the edge of the final handshake. `busy` is already 0 in that cycle.
- While `res_valid`=1 and `res_ready`=0, `res_data` and `res_idx` must stay stable.
- An `rst` assertion mid-run immediately forces all outputs and the register file to their reset values. The pending result is discarded and `done` does not pulse.

## Configuration
- `SEQ_RELU_EN` defined: on capture, if `p_out[7]`=1 (negative in two's complement), `res_data` is forced to 8'h00; otherwise it passes unchanged.
- `SEQ_RELU_EN` undefined: `res_data` = `p_out` unchanged.

## Test plan
- Basic: neuron0 weights all 8'h01, bias 0; `in_vec`=8'hFF; `start` → idx0 `res_data`=8'h08, `res_valid` rises 2 edges after start acceptance.
- Multi-neuron: N=4, neuron1 weight0=3 and bias=5, others 0; `in_vec`=8'h01 → results idx0..3 = 0, 8, 0, 0 in order; `done` pulses once; total 12 cycles.
- Wrap: neuron0 weights all 8'hFF, bias 8'hFF, `in_vec`=8'hFF → `res_data`=8'hF7. With `SEQ_RELU_EN` → 8'h00.
- Backpressure: hold `res_ready`=0 for 5 cycles on idx1 → `res_valid` stays high and `res_data`/`res_idx` stay constant; a `start` pulse and a `cfg_we` write during the stall are ignored, checked by reading results on the next run.
- Reset mid-op: assert `rst` during idx2 CAPT → next cycle `busy`=0 and `res_valid`=0, no `done`; a new run with reloaded weights returns correct values.
- Back-to-back: `start` held high → a second run begins in the `done` cycle; the idx sequence repeats 0..3.
